// File: rtl/mcf_subframe_sched_if.sv
// Settings write bus plus packet-request handshake shared by the McF scheduler and its source datapath.
// master: the scheduler side; slave: the settings writer / datapath side.
interface mcf_subframe_sched_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        pkt_req_valid;
    logic        pkt_req_ready;
    logic [15:0] pkt_req_len;
    logic        pkt_req_sof;
    logic        pkt_req_eob;

    modport master (
        input  set_stb, set_addr, set_data, pkt_req_ready,
        output pkt_req_valid, pkt_req_len, pkt_req_sof, pkt_req_eob
    );

    modport slave (
        output set_stb, set_addr, set_data, pkt_req_ready,
        input  pkt_req_valid, pkt_req_len, pkt_req_sof, pkt_req_eob
    );
endinterface

// File: rtl/mcf_subframe_sched.sv
// Paced packet scheduler for the McF sample source: sample-rate credit accounting,
// per-packet length requests, subframe boundary (sof) and end-of-burst (eob) marking.
module mcf_subframe_sched (
    input  logic                        ce_clk,
    input  logic                        ce_rst,
    mcf_subframe_sched_if.master        bus,
    output logic                        sample_tick,
    output logic                        running,
    output logic [31:0]                 subframe_cnt,
    output logic                        overrun,
    output logic                        cfg_err
);
    localparam logic [7:0] SR_ENABLE         = 8'd129;
    localparam logic [7:0] SR_SAMPLE_LEN_1MS = 8'd130;
    localparam logic [7:0] SR_SPP            = 8'd131;
    localparam logic [7:0] SR_CLK_DIV        = 8'd132;

    typedef enum logic [1:0] {IDLE, WAIT, REQ} state_t;
    state_t state, state_nxt;

    logic [15:0] spp, slen, div;
    logic        en;
    logic [15:0] div_eff, div_cnt, div_lat;
    logic [15:0] credit, credit_inc, rem, rem_after, len;
    logic        stop_pend, sof_pend;
    logic        wr_en, start, start_bad, tick, fire, hs;
    logic        unused_cfg;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            spp  <= '0;
            slen <= '0;
            div  <= '0;
            en   <= 1'b0;
        end else if (bus.set_stb) begin
            case (bus.set_addr)
                SR_ENABLE:         en   <= bus.set_data[0];
                SR_SAMPLE_LEN_1MS: slen <= bus.set_data[15:0];
                SR_SPP:            spp  <= bus.set_data[15:0];
                SR_CLK_DIV:        div  <= bus.set_data[15:0];
                default: ;
            endcase
        end
    end

    assign unused_cfg = ^{bus.set_data[31:16], en};

    assign wr_en      = bus.set_stb && (bus.set_addr == SR_ENABLE);
    assign start      = (state == IDLE) && wr_en && bus.set_data[0] && (spp != '0) && (slen != '0);
    assign start_bad  = (state == IDLE) && wr_en && bus.set_data[0] && ((spp == '0) || (slen == '0));
    assign div_eff    = (div == '0) ? 16'd1 : div;
    // div_lat holds the period in force, so a new divider only lands at a wrap
    assign tick       = (state != IDLE) && (div_cnt == div_lat - 16'd1);
    assign credit_inc = (tick && credit != 16'hFFFF) ? credit + 16'd1 : credit;
    assign len        = (spp < rem) ? spp : rem;
    assign fire       = (state == WAIT) && (credit_inc >= len);
    assign hs         = (state == REQ) && bus.pkt_req_ready;
    assign rem_after  = rem - bus.pkt_req_len;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (fire)  state_nxt = REQ;
            REQ:     if (hs)    state_nxt = bus.pkt_req_eob ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running           = (state != IDLE);
        bus.pkt_req_valid = (state == REQ);
        sample_tick       = tick;
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            div_cnt          <= '0;
            div_lat          <= '0;
            credit           <= '0;
            rem              <= '0;
            stop_pend        <= 1'b0;
            sof_pend         <= 1'b0;
            subframe_cnt     <= '0;
            overrun          <= 1'b0;
            cfg_err          <= 1'b0;
            bus.pkt_req_len  <= '0;
            bus.pkt_req_sof  <= 1'b0;
            bus.pkt_req_eob  <= 1'b0;
        end else if (start) begin
            div_cnt      <= '0;
            div_lat      <= div_eff;
            credit       <= '0;
            rem          <= slen;
            stop_pend    <= 1'b0;
            sof_pend     <= 1'b1;
            subframe_cnt <= '0;
            overrun      <= 1'b0;
            cfg_err      <= 1'b0;
        end else if (start_bad) begin
            cfg_err <= 1'b1;
        end else if (state != IDLE) begin
            if (tick) begin
                div_cnt <= '0;
                div_lat <= div_eff;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
            if (tick && credit == 16'hFFFF) overrun <= 1'b1;
            if (wr_en) stop_pend <= ~bus.set_data[0];
            if (fire) begin
                bus.pkt_req_len <= len;
                bus.pkt_req_sof <= sof_pend;
                bus.pkt_req_eob <= stop_pend && (len == rem);
            end
            // Credit already covers the request, so the subtraction cannot wrap
            if (hs) begin
                credit <= credit_inc - bus.pkt_req_len;
                if (rem_after == '0) begin
                    subframe_cnt <= subframe_cnt + 32'd1;
                    rem          <= slen;
                    sof_pend     <= 1'b1;
                end else begin
                    rem      <= rem_after;
                    sof_pend <= 1'b0;
                end
            end else begin
                credit <= credit_inc;
            end
        end
    end
endmodule
